// File: rtl/vram_arbiter_pkg.sv
// vram_pkg: shared types and sizes for the VRAM arbiter slice.
// Contents:
//   VRAM_AW / VRAM_DW / VRAM_CNT_W : default address, data and counter widths
//   vram_gnt_t : which source owns the RAM port for the next cycle
//   vram_tag_t : who a read in flight belongs to
package vram_pkg;

   localparam int VRAM_AW    = 13;
   localparam int VRAM_DW    = 8;
   localparam int VRAM_CNT_W = 16;

   // One grant per edge; WB only ever appears when the posted write buffer is built in.
   typedef enum logic [2:0] {
      GNT_IDLE,
      GNT_ULA,
      GNT_CPU_RD,
      GNT_CPU_WR,
      GNT_WB
   } vram_gnt_t;

   // Owner of a read travelling through the two-stage return pipeline.
   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_ULA,
      TAG_CPU
   } vram_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the three buses around the arbiter.
//   ULA side : ula_req, ula_addr -> ula_data, ula_valid
//   CPU side : cpu_req, cpu_we, cpu_addr, cpu_din -> cpu_dout, cpu_ready
//   RAM side : ram_en, ram_we, ram_addr, ram_din <- ram_dout
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system (ULA, J1 decoder, RAM macro)
interface vram_arbiter_if import vram_pkg::*; #(
   parameter int AW = VRAM_AW,
   parameter int DW = VRAM_DW
);

   logic          ula_req;
   logic [AW-1:0] ula_addr;
   logic [DW-1:0] ula_data;
   logic          ula_valid;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic [DW-1:0] cpu_dout;
   logic          cpu_ready;

   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  ula_req, ula_addr,
      output ula_data, ula_valid,
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      output cpu_dout, cpu_ready,
      output ram_en, ram_we, ram_addr, ram_din,
      input  ram_dout
   );

   modport master (
      output ula_req, ula_addr,
      input  ula_data, ula_valid,
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      input  cpu_dout, cpu_ready,
      input  ram_en, ram_we, ram_addr, ram_din,
      output ram_dout
   );

endinterface

// File: rtl/vram_arbiter_wbuf.sv
// vram_wbuf: one-entry posted write buffer for CPU writes into VRAM.
// Only instantiated when VRAM_WBUF_EN is defined.
// Ports:
//   clk, rst     : pixel clock, async active-low reset
//   wrReq_i      : a CPU write is pending and not yet accepted
//   wrAddr_i     : write address
//   wrData_i     : write data
//   drain_i      : the arbiter is granting WB this edge
//   accept_o     : the write is taken into the buffer this edge
//   full_o       : buffer holds a write not yet in RAM
//   addr_o       : buffered address
//   data_o       : buffered data
module vram_wbuf import vram_pkg::*; #(
   parameter int AW = VRAM_AW,
   parameter int DW = VRAM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wrReq_i,
   input  logic [AW-1:0] wrAddr_i,
   input  logic [DW-1:0] wrData_i,
   input  logic          drain_i,
   output logic          accept_o,
   output logic          full_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o
);

   logic          full_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;

   // A new write is only taken into an empty buffer; a write arriving while full simply
   // waits (the CPU keeps cpu_req up) until the drain has emptied the entry.
   assign accept_o = wrReq_i && !full_q;
   assign full_o   = full_q;
   assign addr_o   = addr_q;
   assign data_o   = data_q;

   // Accept and drain never coincide: drain needs a full buffer, accept needs an empty one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (accept_o) begin
         full_q <= 1'b1;
         addr_q <= wrAddr_i;
         data_q <= wrData_i;
      end else if (drain_i) begin
         full_q <= 1'b0;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between the ULA display fetch and the J1 CPU.
// The ULA always wins; the CPU is stalled through its ready handshake.
// Ports:
//   clk, rst        : 7 MHz pixel clock, async active-low reset
//   bus (slave)     : ULA fetch, CPU data port and RAM macro signals
//   contention_cnt  : saturating count of cycles a CPU request was denied
// Build option:
//   VRAM_WBUF_EN    : adds a one-entry posted write buffer (vram_wbuf) and the WB grant
module vram_arbiter import vram_pkg::*; #(
   parameter int AW    = VRAM_AW,
   parameter int DW    = VRAM_DW,
   parameter int CNT_W = VRAM_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   vram_arbiter_if.slave    bus,
   output logic [CNT_W-1:0] contention_cnt
);

   vram_gnt_t        gnt_d;
   vram_gnt_t        gnt_q;
   vram_tag_t        tag1_q;
   vram_tag_t        tag2_q;
   logic             cpuBusy_q;
   logic             cpuPend;
   logic             cpuGrant;
   logic             wrAccept;
   logic             ramEn_q;
   logic             ramWe_q;
   logic [AW-1:0]    ramAddr_q;
   logic [DW-1:0]    ramDin_q;
   logic [DW-1:0]    ulaData_q;
   logic             ulaValid_q;
   logic [DW-1:0]    cpuDout_q;
   logic             cpuReady_q;
   logic [CNT_W-1:0] cnt_q;

   // A CPU request counts only until it has been taken; the busy flag covers it until
   // the ready pulse so a still-high cpu_req in the ready cycle is not taken twice.
   assign cpuPend = bus.cpu_req && !cpuBusy_q;

`ifdef VRAM_WBUF_EN
   logic          wbFull;
   logic [AW-1:0] wbAddr;
   logic [DW-1:0] wbData;

   vram_wbuf #(.AW(AW), .DW(DW)) uWbuf (
      .clk      (clk),
      .rst      (rst),
      .wrReq_i  (cpuPend && bus.cpu_we),
      .wrAddr_i (bus.cpu_addr),
      .wrData_i (bus.cpu_din),
      .drain_i  (gnt_d == GNT_WB),
      .accept_o (wrAccept),
      .full_o   (wbFull),
      .addr_o   (wbAddr),
      .data_o   (wbData)
   );
`else
   assign wrAccept = 1'b0;
`endif

   // Priority: ULA, then a buffered write, then the CPU. With the buffer built in, CPU
   // writes never take the port directly and reads wait for the buffer to empty, which
   // keeps read-after-write ordering.
   always_comb begin
      gnt_d = GNT_IDLE;
      if (bus.ula_req) begin
         gnt_d = GNT_ULA;
      end
`ifdef VRAM_WBUF_EN
      else if (wbFull) begin
         gnt_d = GNT_WB;
      end else if (cpuPend && !bus.cpu_we) begin
         gnt_d = GNT_CPU_RD;
      end
`else
      else if (cpuPend) begin
         gnt_d = bus.cpu_we ? GNT_CPU_WR : GNT_CPU_RD;
      end
`endif
   end

   assign cpuGrant = (gnt_d == GNT_CPU_RD) || (gnt_d == GNT_CPU_WR) || wrAccept;

   // Grant register, registered RAM strobes, read-return tags and output captures.
   // A read granted at edge E0 is on the RAM pins after E0, its data comes back one
   // cycle later, and the owner's output register captures it at the following edge.
   // Direct writes complete the cycle after they are on the pins; posted writes
   // complete as soon as the buffer accepts them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q      <= GNT_IDLE;
         tag1_q     <= TAG_NONE;
         tag2_q     <= TAG_NONE;
         cpuBusy_q  <= 1'b0;
         ramEn_q    <= 1'b0;
         ramWe_q    <= 1'b0;
         ramAddr_q  <= '0;
         ramDin_q   <= '0;
         ulaData_q  <= '0;
         ulaValid_q <= 1'b0;
         cpuDout_q  <= '0;
         cpuReady_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         gnt_q   <= gnt_d;
         ramEn_q <= (gnt_d != GNT_IDLE);
         ramWe_q <= (gnt_d == GNT_CPU_WR) || (gnt_d == GNT_WB);
         case (gnt_d)
            GNT_ULA:    ramAddr_q <= bus.ula_addr;
            GNT_CPU_RD: ramAddr_q <= bus.cpu_addr;
            GNT_CPU_WR: begin
               ramAddr_q <= bus.cpu_addr;
               ramDin_q  <= bus.cpu_din;
            end
`ifdef VRAM_WBUF_EN
            GNT_WB: begin
               ramAddr_q <= wbAddr;
               ramDin_q  <= wbData;
            end
`endif
            default: ;
         endcase

         tag1_q <= (gnt_d == GNT_ULA)    ? TAG_ULA :
                   (gnt_d == GNT_CPU_RD) ? TAG_CPU : TAG_NONE;
         tag2_q <= tag1_q;

         ulaValid_q <= (tag2_q == TAG_ULA);
         if (tag2_q == TAG_ULA) begin
            ulaData_q <= bus.ram_dout;
         end
         if (tag2_q == TAG_CPU) begin
            cpuDout_q <= bus.ram_dout;
         end
         cpuReady_q <= (tag2_q == TAG_CPU) || (gnt_q == GNT_CPU_WR) || wrAccept;

         if (cpuGrant) begin
            cpuBusy_q <= 1'b1;
         end else if (cpuReady_q) begin
            cpuBusy_q <= 1'b0;
         end

         if (cpuPend && !cpuGrant && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.ula_data   = ulaData_q;
   assign bus.ula_valid  = ulaValid_q;
   assign bus.cpu_dout   = cpuDout_q;
   assign bus.cpu_ready  = cpuReady_q;
   assign bus.ram_en     = ramEn_q;
   assign bus.ram_we     = ramWe_q;
   assign bus.ram_addr   = ramAddr_q;
   assign bus.ram_din    = ramDin_q;
   assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter.
// The whole run is planned up front as per-cycle tables: the planner turns each
// transaction into stimulus plus the cycles in which its effects must show up,
// using the arbitration and latency rules at transaction level. A single compare
// process then checks every DUT output on every cycle against those tables.
// Works for both builds (VRAM_WBUF_EN defined or not).
module tb_vram_arbiter;
   import vram_pkg::*;

   localparam int NCYC = 76;
   localparam int NARR = NCYC + 8;

   logic        clk = 1'b1;
   logic        rst = 1'b1;
   logic [15:0] contentionCnt;

   vram_arbiter_if bus ();

   vram_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .contention_cnt (contentionCnt)
   );

   always #5 clk = ~clk;

   // Initial VRAM contents, with the bytes the directed tests rely on pinned.
   function automatic logic [7:0] memInit(input logic [12:0] a);
      case (a)
         13'h1800: return 8'h47;
         13'h0000: return 8'hAA;
         13'h1801: return 8'h3C;
         13'h0001: return 8'h5A;
         13'h1ABC: return 8'h00;
         default:  return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hC3;
      endcase
   endfunction

   // RAM macro model: synchronous single port, read data one cycle after the enable.
   bit         vramWritten [8192];
   logic [7:0] vramWr      [8192];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            vramWritten[bus.ram_addr] <= 1'b1;
            vramWr[bus.ram_addr]      <= bus.ram_din;
         end else begin
            bus.ram_dout <= vramWritten[bus.ram_addr] ? vramWr[bus.ram_addr] : memInit(bus.ram_addr);
         end
      end
   end

   // Stimulus tables and expected-value tables, one slot per cycle.
   bit          rstLowAt   [NARR];
   bit          ulaAt      [NARR];
   logic [12:0] ulaAddrAt  [NARR];
   bit          cpuReqAt   [NARR];
   bit          cpuWeAt    [NARR];
   logic [12:0] cpuAddrAt  [NARR];
   logic [7:0]  cpuDinAt   [NARR];
   bit          deniedAt   [NARR];
   bit          wbFullAt   [NARR];
   bit          expEn      [NARR];
   bit          expWe      [NARR];
   logic [12:0] expAddr    [NARR];
   logic [7:0]  expDin     [NARR];
   bit          expUlaV    [NARR];
   logic [7:0]  expUlaD    [NARR];
   bit          expRdy     [NARR];
   bit          expDoutChk [NARR];
   logic [7:0]  expDout    [NARR];
   logic [7:0]  shadow     [8192];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          cntModel = 0;
   logic [7:0]  ulaHold = '0;
   logic [7:0]  doutHold = '0;
   int          rdyRead20, rdySim30, rdyWr40, weWr40, rdyRd2, rdyPre64;

   // A ULA fetch always wins its edge, so its result lands exactly three cycles later.
   task automatic planUla(input int c, input logic [12:0] a);
      ulaAt[c]     = 1'b1;
      ulaAddrAt[c] = a;
      expEn[c+1]   = 1'b1;
      expAddr[c+1] = a;
      expUlaV[c+3] = 1'b1;
      expUlaD[c+3] = shadow[a];
   endtask

   // A CPU read is granted at the first cycle with no ULA fetch and no buffered write;
   // every cycle before that is a denied cycle. The request is held through ready.
   task automatic planCpuRead(input int c, input logic [12:0] a, output int rdy);
      int g = c;
      while (g < NCYC && (ulaAt[g] || wbFullAt[g])) begin
         deniedAt[g] = 1'b1;
         g++;
      end
      expEn[g+1]      = 1'b1;
      expAddr[g+1]    = a;
      rdy             = g + 3;
      expRdy[rdy]     = 1'b1;
      expDoutChk[rdy] = 1'b1;
      expDout[rdy]    = shadow[a];
      for (int k = c; k <= rdy; k++) begin
         cpuReqAt[k]  = 1'b1;
         cpuWeAt[k]   = 1'b0;
         cpuAddrAt[k] = a;
      end
   endtask

   // Posted: acknowledged next cycle, RAM write one cycle after the first ULA-free cycle.
   // Direct: waits like a read, write on the pins after the grant, ready one cycle later.
   task automatic planCpuWrite(input int c, input logic [12:0] a, input logic [7:0] d,
                               output int rdy, output int weCyc);
      int g = c;
`ifdef VRAM_WBUF_EN
      rdy = c + 1;
      g   = c + 1;
      while (g < NCYC && ulaAt[g]) g++;
      for (int k = c + 1; k <= g; k++) wbFullAt[k] = 1'b1;
      weCyc = g + 1;
`else
      while (g < NCYC && ulaAt[g]) begin
         deniedAt[g] = 1'b1;
         g++;
      end
      weCyc = g + 1;
      rdy   = g + 2;
`endif
      expEn[weCyc]   = 1'b1;
      expWe[weCyc]   = 1'b1;
      expAddr[weCyc] = a;
      expDin[weCyc]  = d;
      expRdy[rdy]    = 1'b1;
      shadow[a]      = d;
      for (int k = c; k <= rdy; k++) begin
         cpuReqAt[k]  = 1'b1;
         cpuWeAt[k]   = 1'b1;
         cpuAddrAt[k] = a;
         cpuDinAt[k]  = d;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
      end
   endtask

   // Drive one cycle's worth of inputs from the tables.
   task automatic applyStimulus(input int k);
      rst          = !rstLowAt[k];
      bus.ula_req  = ulaAt[k];
      bus.ula_addr = ulaAddrAt[k];
      bus.cpu_req  = cpuReqAt[k];
      bus.cpu_we   = cpuWeAt[k];
      bus.cpu_addr = cpuAddrAt[k];
      bus.cpu_din  = cpuDinAt[k];
   endtask

   // Hand-computed timings that anchor the planner itself.
   task automatic pinModel();
      check("modelUlaData13", expUlaD[13], 8'h47);
      check("modelRead20Rdy", rdyRead20, 23);
      check("modelSim30Rdy", rdySim30, 34);
      check("modelWr40We", weWr40, 44);
`ifdef VRAM_WBUF_EN
      check("modelWr40Rdy", rdyWr40, 41);
      check("modelRd42Rdy", rdyRd2, 47);
      check("modelRd42Data", expDout[47], 8'h55);
`else
      check("modelWr40Rdy", rdyWr40, 45);
      check("modelRd46Rdy", rdyRd2, 49);
`endif
      check("modelPre64Rdy", rdyPre64, 69);
   endtask

   // Every cycle: reset cycles expect all-zero outputs; otherwise every output is
   // compared with the planned tables, data outputs holding their last pulse value.
   task automatic checkOutput(input int k);
      if (k == 0) pinModel();
      if (rstLowAt[k]) begin
         ulaHold  = '0;
         doutHold = '0;
         cntModel = 0;
         check("rstUlaValid", bus.ula_valid, 0);
         check("rstUlaData", bus.ula_data, 0);
         check("rstCpuReady", bus.cpu_ready, 0);
         check("rstCpuDout", bus.cpu_dout, 0);
         check("rstRamEn", bus.ram_en, 0);
         check("rstRamWe", bus.ram_we, 0);
         check("rstRamAddr", bus.ram_addr, 0);
         check("rstRamDin", bus.ram_din, 0);
         check("rstCount", contentionCnt, 0);
      end else begin
         if (expUlaV[k]) ulaHold = expUlaD[k];
         if (expRdy[k] && expDoutChk[k]) doutHold = expDout[k];
         check("ulaValid", bus.ula_valid, expUlaV[k]);
         check("ulaData", bus.ula_data, ulaHold);
         check("cpuReady", bus.cpu_ready, expRdy[k]);
         check("cpuDout", bus.cpu_dout, doutHold);
         check("ramEn", bus.ram_en, expEn[k]);
         check("ramWe", bus.ram_we, expWe[k]);
         if (expEn[k]) check("ramAddr", bus.ram_addr, expAddr[k]);
         if (expWe[k]) check("ramDin", bus.ram_din, expDin[k]);
         check("contention", contentionCnt, cntModel);
         if (deniedAt[k]) cntModel++;
      end
   endtask

   always @(negedge clk) checkOutput(cyc);

   // Plan the directed scenarios in time order, then run the tables cycle by cycle.
   initial begin
      int dummy;
      for (int i = 0; i < 8192; i++) shadow[i] = memInit(13'(i));

      for (int k = 0; k < 3; k++) rstLowAt[k] = 1'b1;

      planUla(10, 13'h1800);

      planCpuRead(20, 13'h0000, rdyRead20);

      planUla(30, 13'h1801);
      planCpuRead(30, 13'h0001, rdySim30);

      planUla(40, 13'h1802);
      planUla(41, 13'h1803);
      planUla(42, 13'h1804);
      planCpuWrite(40, 13'h1ABC, 8'h55, rdyWr40, weWr40);
`ifdef VRAM_WBUF_EN
      planCpuRead(42, 13'h1ABC, rdyRd2);
`else
      planCpuRead(46, 13'h1ABC, rdyRd2);
`endif

      cpuReqAt[50]  = 1'b1;
      cpuAddrAt[50] = 13'h0002;
      for (int k = 51; k < 54; k++) rstLowAt[k] = 1'b1;

      planUla(60, 13'h1805);
      planUla(64, 13'h1806);
      planUla(65, 13'h1807);
      planCpuRead(64, 13'h0001, rdyPre64);
      dummy = 0;

      #1 applyStimulus(0);
      for (int k = 1; k < NCYC; k++) begin
         @(posedge clk);
         cyc = k;
         #1 applyStimulus(k);
      end
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 8 KB video RAM between the ULA display fetch and the J1 CPU data port. The ULA always has priority so the raster never loses a byte. CPU reads and writes are stalled with a ready handshake while the ULA holds the RAM. The block sits between `ula`, the J1 bus decoder and the VRAM macro, in the 7 MHz pixel-clock domain.

## Interface
- `AW`, 13: VRAM address width (8192 bytes: bitmap 0x0000–0x17FF, attributes 0x1800–0x1AFF).
- `DW`, 8: VRAM data width.
- `CNT_W`, 16: width of the contention counter.

Ports:
- `clk`  in  1  pixel clock, 7 MHz; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; deassertion is synchronised outside the block.
- `ula_req`  in  1  one-cycle fetch strobe from the ULA.
- `ula_addr`  in  AW  fetch address; sampled with `ula_req`.
- `ula_data`  out  DW  fetched byte.
- `ula_valid`  out  1  one-cycle pulse qualifying `ula_data`.
- `cpu_req`  in  1  CPU access request; held until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  AW  CPU address; stable while `cpu_req` is high.
- `cpu_din`  in  DW  CPU write data.
- `cpu_dout`  out  DW  CPU read data; valid with `cpu_ready` for reads.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data, valid one cycle after an `ram_en` read.
- `contention_cnt`  out  CNT_W  saturating count of cycles the CPU was denied.

## Operation
- Grant is decided at each rising edge among the pending sources. Priority order: ULA, then the write buffer (if compiled in), then the CPU.
- Grant state (`gnt`): IDLE, ULA, CPU_RD, CPU_WR, WB.
  - The next grant is chosen every cycle. Back-to-back grants are allowed.
  - No state lingers longer than one cycle.
- A ULA request is never queued or dropped. If `ula_req` is high, the ULA wins that edge unconditionally.
- CPU request:
  - It is accepted once. An internal `cpu_busy` flag blocks re-grant until `cpu_ready` has been issued.
  - The CPU must drop `cpu_req` or present a new request in the cycle after `cpu_ready`.
- `contention_cnt` increments in every cycle where a CPU request is pending, not in flight, and not granted. It saturates at all-ones and is cleared only by reset.
- Read-return pipeline:
  - A 2-stage tag shift register (ULA / CPU / none) follows every read grant.
  - `ram_dout` is captured into `ula_data` or `cpu_dout` according to the tag.
- `ula_data` and `cpu_dout` hold their last value between pulses.
- Reset:
  - All outputs go to 0: `ula_data`, `ula_valid`, `cpu_dout`, `cpu_ready`, `ram_en`, `ram_we`, `ram_addr`, `ram_din`, `contention_cnt`.
  - Tags, `cpu_busy`, grant state and the write buffer are cleared.
- Reset mid-operation: in-flight reads are discarded. No `ula_valid` or `cpu_ready` pulse appears after reset for a request issued before it.

## Timing
- `ram_*` outputs are registered. The grant taken at edge E0 drives `ram_en` in the cycle after E0.
- ULA latency is fixed. With `ula_req` high in cycle c, `ula_valid` is high in cycle c+3.
- CPU read:
  - Uncontended: `cpu_req` first high in cycle c gives `cpu_ready` in c+3.
  - Each cycle of ULA preemption adds exactly one cycle.
- CPU write, unbuffered: `ram_we` is high in c+1 and `cpu_ready` in c+2 (uncontended).
- Simultaneous ULA and CPU request in cycle c: the ULA is granted at c and the CPU at c+1. `contention_cnt` increments by 1.

## Configuration
- `VRAM_WBUF_EN` defined: adds a one-entry posted write buffer.
  - A CPU write with the buffer empty is accepted at once: `cpu_ready` in c+1.
  - The buffer drains via grant WB at the first edge with no `ula_req`.
  - A write arriving while the buffer is full is held (stalled) until the buffer drains, then accepted.
  - A CPU read is not granted while the buffer is full. This guarantees read-after-write ordering.
- `VRAM_WBUF_EN` undefined: writes go directly through the CPU_WR grant with the unbuffered timing above. WB state and buffer logic are absent.

## Structure
- Package `vram_pkg` holds:
  - `VRAM_AW`, `VRAM_DW`.
  - The grant enum `vram_gnt_t` (IDLE, ULA, CPU_RD, CPU_WR, WB).
  - The tag enum `vram_tag_t` (NONE, ULA, CPU).
- One sub-module, `vram_wbuf`. It contains the buffer registers, the full flag and the accept/drain handshake. It is instantiated only under `VRAM_WBUF_EN`.

## Test plan
- ULA only: `ula_req` with 0x1800 in cycle 10, RAM model returns 0x47 → `ula_valid`=1 in cycle 13, `ula_data`=0x47, `cpu_ready` stays 0.
- CPU read alone: `cpu_addr`=0x0000, memory 0xAA, `cpu_req` from cycle 20 → `cpu_ready` in cycle 23, `cpu_dout`=0xAA, `contention_cnt`=0.
- Simultaneous ULA (0x1801) and CPU read (0x0001) in cycle 30 → `ula_valid` in cycle 33, `cpu_ready` in cycle 34, `contention_cnt`=1.
- Write with `VRAM_WBUF_EN`, addr 0x1ABC, data 0x55, while ULA requests in cycles 40–42:
  - `cpu_ready` in cycle 41.
  - `ram_we`=1 with 0x1ABC/0x55 in cycle 44.
  - A read of 0x1ABC issued in cycle 42 returns 0x55.
- Without `VRAM_WBUF_EN`, same stimulus → `ram_we` in cycle 44, `cpu_ready` in cycle 45.
- `rst` asserted in cycle 51 after a CPU read is accepted in cycle 50:
  - All outputs read 0 during reset.
  - No `cpu_ready` follows release.
  - `contention_cnt`=0.
